// File: rtl/prog_buttons_ctrl_pkg.sv
// prog_buttons_ctrl_pkg: field indices, register addresses, BCD limits and FSM states for button programming
package prog_buttons_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, EDIT, WRITE} state_t;
  localparam logic [2:0] F_SEC = 3'd0, F_MIN = 3'd1, F_HOUR = 3'd2, F_DAY = 3'd3, F_MONTH = 3'd4, F_YEAR = 3'd5;
  localparam logic [3:0] A_SEC = 4'h0, A_MIN = 4'h1, A_HOUR = 4'h2, A_DAY = 4'h4, A_MONTH = 4'h5, A_YEAR = 4'h6;
  function automatic logic [3:0] field_addr(input logic [2:0] f);
    return f == F_SEC ? A_SEC : f == F_MIN ? A_MIN : f == F_HOUR ? A_HOUR :
           f == F_DAY ? A_DAY : f == F_MONTH ? A_MONTH : A_YEAR;
  endfunction
  function automatic logic [7:0] field_min(input logic [2:0] f);
    return (f == F_DAY || f == F_MONTH) ? 8'h01 : 8'h00;
  endfunction
  function automatic logic [7:0] field_max(input logic [2:0] f);
    return f == F_HOUR ? 8'h23 : f == F_DAY ? 8'h31 : f == F_MONTH ? 8'h12 :
           f == F_YEAR ? 8'h99 : 8'h59;
  endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer, stable-level counter and one-cycle press pulse on accepted rise
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic lvl, flip, done;
  logic [CW-1:0] cnt;
  assign flip = sync[1] != lvl;
  assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '0;
      cnt   <= '0;
      lvl   <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      cnt   <= (flip && !done) ? cnt + CW'(1) : '0;
      lvl   <= (flip && done) ? sync[1] : lvl;
      press <= flip && done && sync[1];
    end
  end
endmodule

// File: rtl/prog_buttons_ctrl.sv
// prog_buttons_ctrl: pushbutton editing of BCD clock/date fields with single-cycle register-bank writes
module prog_buttons_ctrl
  import prog_buttons_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       prog_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [7:0] rd_data,
  output logic [3:0] addr,
  output logic [7:0] wr_data,
  output logic       we_prog,
  output logic [2:0] field
);
  logic [3:0] btn, pr;
  state_t state, state_d;
  logic [2:0] field_d;
  logic [7:0] wv, wv_d;
  logic pm_q;
  assign btn = {btn_left, btn_right, btn_down, btn_up};
  for (genvar g = 0; g < 4; g++) begin : g_db
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset_n(reset_n), .btn(btn[g]), .press(pr[g])
    );
  end
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [2:0] f);
    return v == field_max(f) ? field_min(f) : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [2:0] f);
    return v == field_min(f) ? field_max(f) : v[3:0] == 4'd0 ? {v[7:4] - 4'd1, 4'd9} : v - 8'd1;
  endfunction
  // Valid BCD orders like binary, so range limits compare directly.
  function automatic logic [7:0] clamp(input logic [7:0] v, input logic [2:0] f);
    return (v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && v >= field_min(f) && v <= field_max(f)) ? v : field_min(f);
  endfunction
  always_comb begin
    state_d = state;
    field_d = field;
    wv_d    = wv;
    if (!prog_mode) state_d = IDLE;
    else case (state)
      IDLE: state_d = pm_q ? IDLE : LOAD;
      LOAD: begin
        wv_d    = clamp(rd_data, field);
        state_d = EDIT;
      end
      EDIT: begin
        if (pr[0]) begin
          wv_d    = bcd_inc(wv, field);
          state_d = WRITE;
        end else if (pr[1]) begin
          wv_d    = bcd_dec(wv, field);
          state_d = WRITE;
        end else if (pr[2]) begin
          field_d = field == F_YEAR ? F_SEC : field + 3'd1;
          state_d = LOAD;
        end else if (pr[3]) begin
          field_d = field == F_SEC ? F_YEAR : field - 3'd1;
          state_d = LOAD;
        end
      end
      WRITE: state_d = EDIT;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      field <= F_SEC;
      wv    <= 8'h00;
      pm_q  <= 1'b0;
    end else begin
      state <= state_d;
      field <= field_d;
      wv    <= wv_d;
      pm_q  <= prog_mode;
    end
  end
  assign addr    = field_addr(field);
  assign wr_data = wv;
  assign we_prog = state == WRITE;
endmodule
